branch_condition_unit: RTL

Consumer of the ALU's `FLAGS_T` output. Holds the architectural flags register, which is written from each valid ALU result. Resolves conditional branches against those flags through a valid/ready handshake, with one registered output stage. Provides a small flags save/restore stack for interrupt entry and exit. Sits between the execute stage (ALU) and the fetch/PC-redirect logic.

---
 rtl/branch_condition_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/branch_condition_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_condition_unit
// Description : Architectural flags register with same-cycle forwarding,
//               conditional-branch resolution behind a one-deep output
//               register, and a small flags save/restore stack.
// Revision    : 1.0 - initial release
// ============================================================================
// Flag vector layout (MSB..LSB): {overflow, carry, zero, negative}.
module branch_condition_unit #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_flags,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [3:0]  br_cond,
    input  logic [15:0] br_target,
    input  logic [15:0] br_fallthru,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_taken,
    output logic [15:0] res_pc,
    input  logic        flags_save,
    input  logic        flags_restore,
    output logic [3:0]  flags_q,
    output logic        stack_err
);

    localparam int c_AW = $clog2(STACK_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(STACK_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_AW-1:0] c_IDX_ONE  = c_AW'(1);

    localparam int c_V = 3;
    localparam int c_C = 2;
    localparam int c_Z = 1;
    localparam int c_N = 0;

    logic [3:0]      r_flags;
    logic [3:0]      r_stack [STACK_DEPTH];
    logic [c_CW-1:0] r_count;
    logic            r_stack_err;
    logic            r_res_valid;
    logic            r_res_taken;
    logic [15:0]     r_res_pc;

    logic [3:0]      w_flags_eff;
    logic            w_taken;
    logic            w_br_ready;
    logic            w_accept;
    logic            w_full;
    logic            w_empty;
    logic            w_save_only;
    logic            w_restore_only;
    logic            w_push;
    logic            w_pop;
    logic            w_err;
    logic [c_AW-1:0] w_push_idx;
    logic [c_AW-1:0] w_top_idx;
    logic [3:0]      w_top;

    // Forwarding lets a branch in the same cycle as an ALU write see new flags
    assign w_flags_eff = alu_valid ? alu_flags : r_flags;

    always_comb begin
        w_taken = 1'b0;
        case (br_cond)
            4'd0:    w_taken =  w_flags_eff[c_Z];
            4'd1:    w_taken = !w_flags_eff[c_Z];
            4'd2:    w_taken =  w_flags_eff[c_C];
            4'd3:    w_taken = !w_flags_eff[c_C];
            4'd4:    w_taken =  w_flags_eff[c_N];
            4'd5:    w_taken = !w_flags_eff[c_N];
            4'd6:    w_taken =  w_flags_eff[c_V];
            4'd7:    w_taken = !w_flags_eff[c_V];
            4'd8:    w_taken = !w_flags_eff[c_C] && !w_flags_eff[c_Z];
            4'd9:    w_taken =  w_flags_eff[c_C] ||  w_flags_eff[c_Z];
            4'd10:   w_taken = !w_flags_eff[c_C];
            4'd11:   w_taken =  w_flags_eff[c_C];
            4'd14:   w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_br_ready = !r_res_valid || res_ready;
    assign w_accept   = br_valid && w_br_ready;

    // Save and restore together cancel out: no stack movement, no error
    assign w_full         = (r_count == c_CNT_FULL);
    assign w_empty        = (r_count == '0);
    assign w_save_only    = flags_save && !flags_restore;
    assign w_restore_only = flags_restore && !flags_save;
    assign w_push         = w_save_only && !w_full;
    assign w_pop          = w_restore_only && !w_empty;
    assign w_err          = (w_save_only && w_full) || (w_restore_only && w_empty);

    assign w_push_idx = r_count[c_AW-1:0];
    assign w_top_idx  = r_count[c_AW-1:0] - c_IDX_ONE;
    assign w_top      = r_stack[w_top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags     <= '0;
            r_count     <= '0;
            r_stack_err <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_taken <= 1'b0;
            r_res_pc    <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_res_valid <= 1'b1;
                r_res_taken <= w_taken;
                r_res_pc    <= w_taken ? br_target : br_fallthru;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end

            // An ALU write wins over a pop; the popped value is dropped
            if (alu_valid) begin
                r_flags <= alu_flags;
            end else if (w_pop) begin
                r_flags <= w_top;
            end

            if (w_push) begin
                r_stack[w_push_idx] <= w_flags_eff;
                r_count             <= r_count + c_CNT_ONE;
            end else if (w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end

            if (w_err) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    assign br_ready  = w_br_ready;
    assign res_valid = r_res_valid;
    assign res_taken = r_res_taken;
    assign res_pc    = r_res_pc;
    assign flags_q   = r_flags;
    assign stack_err = r_stack_err;

endmodule
`default_nettype wire
